pipeline2_decode: RTL and testbench

- Second (decode) stage of the lab processor pipeline; consumes `instr`, `pc_out` and `done` from the fetch stage `pipeline1`.
- Splits the instruction into fields, reads two source registers from an internal register file and sign-extends the immediate.
- Registers the results for the execute stage.
- Detects load-use hazards and handles flush and stall.

---
 rtl/pipeline2_decode_pkg.sv | 37 +++
 rtl/pipeline2_decode_if.sv | 44 ++++
 rtl/pipeline2_decode_regfile.sv | 48 ++++
 rtl/pipeline2_decode.sv | 115 +++++++++++
 tb/tb_pipeline2_decode.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline2_decode_pkg.sv
// Shared processor parameters: datapath widths, instruction field
// positions and opcode constants used by the decode and execute stages.
package pipeline2_decode_pkg;

    localparam int PC_WIDTH       = 16;
    localparam int INSTR_WIDTH    = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int OPCODE_WIDTH   = 6;

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_WIDTH = IMM_MSB - IMM_LSB + 1;

    // Execute stage raises ex_load when its opcode matches this
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD = 6'h23;

    // What the decode pipeline register does on the next edge
    typedef enum logic [1:0] {
        UPD_CAPTURE,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_KILL
    } upd_e;

endpackage

// File: rtl/pipeline2_decode_if.sv
// Decode-stage bus: fetch-side inputs, execute/writeback feedback and
// the registered decode outputs. The decode stage uses the slave view.
interface pipeline2_decode_if #(
    parameter int PC_WIDTH       = pipeline2_decode_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH    = pipeline2_decode_pkg::INSTR_WIDTH,
    parameter int DATA_WIDTH     = pipeline2_decode_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = pipeline2_decode_pkg::REG_ADDR_WIDTH,
    parameter int OPCODE_WIDTH   = pipeline2_decode_pkg::OPCODE_WIDTH
);
    // fetch side
    logic [INSTR_WIDTH-1:0]    instr;
    logic [PC_WIDTH-1:0]       pc_in;
    logic                      valid_in;
    logic                      stall_out;
    // control / feedback
    logic                      flush;
    logic                      stall_in;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_load;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]     wb_data;
    // execute side
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [PC_WIDTH-1:0]       pc_out;
    logic                      valid_out;

    modport master (
        output instr, pc_in, valid_in, flush, stall_in, ex_rd, ex_load,
               wb_en, wb_addr, wb_data,
        input  opcode, rd, rs_data, rt_data, imm, pc_out, valid_out, stall_out
    );

    modport slave (
        input  instr, pc_in, valid_in, flush, stall_in, ex_rd, ex_load,
               wb_en, wb_addr, wb_data,
        output opcode, rd, rs_data, rt_data, imm, pc_out, valid_out, stall_out
    );

endinterface

// File: rtl/pipeline2_decode_regfile.sv
// Register file: 2 combinational read ports, 1 synchronous write port.
// r0 is hardwired to zero; a same-cycle write is forwarded to readers.
module pipeline2_decode_regfile #(
    parameter int DATA_WIDTH = pipeline2_decode_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = pipeline2_decode_pkg::REG_ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    output logic [DATA_WIDTH-1:0] ra_data,
    output logic [DATA_WIDTH-1:0] rb_data
);
    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0][DATA_WIDTH-1:0] mem;

    // Storage: clear on reset, commit writes except to r0
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            mem <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port A: r0 reads zero, otherwise bypass a same-cycle write
    always_comb begin
        ra_data = mem[ra_addr];
        if (ra_addr == '0)
            ra_data = '0;
        else if (wr_en && (wr_addr == ra_addr))
            ra_data = wr_data;
    end

    // Read port B: same rules as port A
    always_comb begin
        rb_data = mem[rb_addr];
        if (rb_addr == '0)
            rb_data = '0;
        else if (wr_en && (wr_addr == rb_addr))
            rb_data = wr_data;
    end

endmodule

// File: rtl/pipeline2_decode.sv
// Decode stage: field extraction, register read, immediate sign
// extension, load-use hazard detection and the decode/execute register.
module pipeline2_decode #(
    parameter int PC_WIDTH       = pipeline2_decode_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH    = pipeline2_decode_pkg::INSTR_WIDTH,
    parameter int DATA_WIDTH     = pipeline2_decode_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = pipeline2_decode_pkg::REG_ADDR_WIDTH,
    parameter int OPCODE_WIDTH   = pipeline2_decode_pkg::OPCODE_WIDTH
) (
    input  logic                clk_in,
    input  logic                RST,
    pipeline2_decode_if.slave   bus
);
    import pipeline2_decode_pkg::*;

    localparam int STAGES = 1;

    logic [OPCODE_WIDTH-1:0]   opc_f;
    logic [REG_ADDR_WIDTH-1:0] rd_f, rs_f, rt_f;
    logic [DATA_WIDTH-1:0]     imm_f;
    logic [DATA_WIDTH-1:0]     rs_rd, rt_rd;
    logic                      hazard;
    upd_e                      upd;

    // Registered state toward execute; vld_pipe[0] is the incoming valid
    logic [STAGES:0]           vld_pipe;
    logic [OPCODE_WIDTH-1:0]   opcode_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     rs_q, rt_q, imm_q;
    logic [PC_WIDTH-1:0]       pc_q;

    assign opc_f = bus.instr[OPC_MSB:OPC_LSB];
    assign rd_f  = bus.instr[RD_MSB:RD_LSB];
    assign rs_f  = bus.instr[RS_MSB:RS_LSB];
    assign rt_f  = bus.instr[RT_MSB:RT_LSB];
    assign imm_f = {{(DATA_WIDTH-IMM_WIDTH){bus.instr[IMM_MSB]}},
                    bus.instr[IMM_MSB:IMM_LSB]};

    assign vld_pipe[0] = bus.valid_in;

    pipeline2_decode_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk_in  (clk_in),
        .RST     (RST),
        .wr_en   (bus.wb_en),
        .wr_addr (bus.wb_addr),
        .wr_data (bus.wb_data),
        .ra_addr (rs_f),
        .rb_addr (rt_f),
        .ra_data (rs_rd),
        .rb_data (rt_rd)
    );

    // Load-use hazard: a load in execute targets a source we are reading.
    // r0 is never a real dependency.
    always_comb begin
        hazard = bus.valid_in & bus.ex_load & (bus.ex_rd != '0) &
                 ((bus.ex_rd == rs_f) | (bus.ex_rd == rt_f));
    end

    // Pick the register update; flush beats stall beats hazard
    always_comb begin
        upd = UPD_CAPTURE;
        if (bus.flush)
            upd = UPD_KILL;
        else if (bus.stall_in)
            upd = UPD_HOLD;
        else if (hazard)
            upd = UPD_BUBBLE;
    end

    // Fetch must hold while we cannot take its instruction; a flush
    // replaces the fetch contents anyway, so never stall on one.
    assign bus.stall_out = !bus.flush & (bus.stall_in | hazard);

    // Decode/execute pipeline register. Kill and bubble only clear the
    // valid bit; the stale payload is harmless behind valid_out=0.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            vld_pipe[STAGES:1] <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
        end else begin
            case (upd)
                UPD_KILL,
                UPD_BUBBLE: vld_pipe[STAGES:1] <= '0;
                UPD_HOLD:   ;
                default: begin
                    vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
                    opcode_q <= opc_f;
                    rd_q     <= rd_f;
                    rs_q     <= rs_rd;
                    rt_q     <= rt_rd;
                    imm_q    <= imm_f;
                    pc_q     <= bus.pc_in;
                end
            endcase
        end
    end

    assign bus.opcode    = opcode_q;
    assign bus.rd        = rd_q;
    assign bus.rs_data   = rs_q;
    assign bus.rt_data   = rt_q;
    assign bus.imm       = imm_q;
    assign bus.pc_out    = pc_q;
    assign bus.valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_pipeline2_decode.sv
// Directed bench for the decode stage: register read/bypass, r0 rule,
// load-use bubble, stall hold, flush priority and asynchronous reset.
module tb_pipeline2_decode;

    logic clk_in;
    logic RST;
    int   checks;
    int   errors;

    pipeline2_decode_if bus ();

    pipeline2_decode dut (
        .clk_in (clk_in),
        .RST    (RST),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] im);
        return {op, rd, rs, im};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.instr    = '0;
        bus.pc_in    = '0;
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;
        bus.ex_rd    = '0;
        bus.ex_load  = 1'b0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [15:0] pc);
        bus.instr    = ins;
        bus.pc_in    = pc;
        bus.valid_in = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        RST = 1'b0;
        step();
        step();
        chk("reset_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("reset_pc", {16'd0, bus.pc_out}, 32'd0);
        chk("reset_rs", bus.rs_data, 32'd0);
        chk("reset_stall", {31'd0, bus.stall_out}, 32'd0);
        RST = 1'b1;

        // write r3 = 0xAA, nothing valid
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAA;
        step();
        chk("idle_valid", {31'd0, bus.valid_out}, 32'd0);

        // rs=3, imm=0xFFF0 (rt field = 31, still zero)
        bus.wb_en = 1'b0;
        issue(mk(6'd8, 5'd2, 5'd3, 16'hFFF0), 16'd20);
        step();
        chk("basic_rs", bus.rs_data, 32'hAA);
        chk("basic_rt", bus.rt_data, 32'h0);
        chk("basic_imm", bus.imm, 32'hFFFF_FFF0);
        chk("basic_pc", {16'd0, bus.pc_out}, 32'd20);
        chk("basic_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("basic_opc", {26'd0, bus.opcode}, 32'd8);
        chk("basic_rd", {27'd0, bus.rd}, 32'd2);

        // same-cycle writeback bypass of r5
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
        issue(mk(6'd1, 5'd6, 5'd5, 16'h0123), 16'd24);
        step();
        chk("bypass_rs", bus.rs_data, 32'h1234);
        chk("pos_imm", bus.imm, 32'h0000_0123);

        // write r0=7 while reading r0 (rs) and r5 (rt field via imm 0x2800)
        bus.wb_addr = 5'd0; bus.wb_data = 32'd7;
        issue(mk(6'd1, 5'd6, 5'd0, 16'h2800), 16'd28);
        step();
        chk("r0_bypass", bus.rs_data, 32'd0);
        chk("r5_commit", bus.rt_data, 32'h1234);

        // later read of r0; write r4 = 0x4444 meanwhile
        bus.wb_addr = 5'd4; bus.wb_data = 32'h4444;
        issue(mk(6'd1, 5'd6, 5'd0, 16'h1800), 16'd32);
        step();
        chk("r0_read", bus.rs_data, 32'd0);
        chk("rt_r3", bus.rt_data, 32'hAA);

        // load-use hazard on rs=4
        bus.wb_en = 1'b0;
        bus.ex_load = 1'b1; bus.ex_rd = 5'd4;
        issue(mk(6'd2, 5'd7, 5'd4, 16'h0000), 16'd36);
        #1;
        chk("haz_stall", {31'd0, bus.stall_out}, 32'd1);
        step();
        chk("haz_bubble", {31'd0, bus.valid_out}, 32'd0);
        chk("haz_pc_hold", {16'd0, bus.pc_out}, 32'd32);

        // load now targets r0: never a hazard even though rt field is 0
        bus.ex_rd = 5'd0;
        #1;
        chk("r0_no_haz", {31'd0, bus.stall_out}, 32'd0);
        step();
        chk("haz_retry_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("haz_retry_pc", {16'd0, bus.pc_out}, 32'd36);
        chk("haz_retry_rs", bus.rs_data, 32'h4444);

        // latch pc=15, then stall 3 cycles with a different instr presented
        bus.ex_load = 1'b0;
        issue(mk(6'd3, 5'd1, 5'd3, 16'h0000), 16'd15);
        step();
        chk("pre_stall_pc", {16'd0, bus.pc_out}, 32'd15);
        bus.stall_in = 1'b1;
        issue(mk(6'd4, 5'd9, 5'd5, 16'h0000), 16'd40);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_out", {31'd0, bus.stall_out}, 32'd1);
            step();
            chk("stall_pc", {16'd0, bus.pc_out}, 32'd15);
            chk("stall_valid", {31'd0, bus.valid_out}, 32'd1);
            chk("stall_rs", bus.rs_data, 32'hAA);
        end

        // flush with stall and hazard all active
        bus.flush = 1'b1; bus.ex_load = 1'b1; bus.ex_rd = 5'd5;
        #1;
        chk("flush_stall_out", {31'd0, bus.stall_out}, 32'd0);
        step();
        chk("flush_valid", {31'd0, bus.valid_out}, 32'd0);

        // normal flow resumes
        bus.flush = 1'b0; bus.stall_in = 1'b0; bus.ex_load = 1'b0;
        issue(mk(6'd4, 5'd9, 5'd5, 16'h8000), 16'd44);
        step();
        chk("resume_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("resume_pc", {16'd0, bus.pc_out}, 32'd44);
        chk("resume_rs", bus.rs_data, 32'h1234);
        chk("resume_imm", bus.imm, 32'hFFFF_8000);

        // asynchronous reset between edges
        #2;
        RST = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("arst_pc", {16'd0, bus.pc_out}, 32'd0);
        chk("arst_rs", bus.rs_data, 32'd0);
        chk("arst_imm", bus.imm, 32'd0);
        chk("arst_opc", {26'd0, bus.opcode}, 32'd0);
        step();
        RST = 1'b1;

        // register file cleared: r3, r5, r4 read zero
        issue(mk(6'd5, 5'd1, 5'd3, 16'h2800), 16'd48);
        step();
        chk("post_rst_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("post_rst_r3", bus.rs_data, 32'd0);
        chk("post_rst_r5", bus.rt_data, 32'd0);
        issue(mk(6'd5, 5'd1, 5'd4, 16'h0000), 16'd52);
        step();
        chk("post_rst_r4", bus.rs_data, 32'd0);
        chk("post_rst_pc", {16'd0, bus.pc_out}, 32'd52);

        // valid_in low yields an empty slot
        bus.valid_in = 1'b0;
        step();
        chk("novalid", {31'd0, bus.valid_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
